// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-addressed data-memory port. Accepts one
//   load/store request at a time, drives MemRead/MemWrite/Address/WriteData,
//   and returns a one-cycle response. Byte and halfword stores are done as a
//   read-modify-write of the containing word. Loads are sign- or zero-extended.
//   Lanes are little-endian: lane k = addr[1:0] sits at bits [8k+7:8k].
//
//   Handshake: a request is taken on the rising CLK edge where
//   req_valid && req_ready. req_ready is high only in IDLE with Reset low. The
//   response is a single-cycle resp_valid pulse with resp_rdata/resp_err
//   valid alongside it. Only the latched copy of the request is used after
//   acceptance.
//
//   Optional feature: define LSU_BOUNDS_CHECK_EN to flag byte addresses with
//   nonzero bits above the memory range as errors. When it is undefined, those
//   bits are ignored and accesses wrap into the ADDR_W word space.
//
// Ports
//   CLK, Reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_write, req_size,        store flag, size (00 b, 01 h, 10 w, 11 illegal),
//   req_signed, req_addr,       load extension, byte address,
//   req_wdata                   right-justified store data
//   resp_valid, resp_rdata,     completion pulse, extended load data,
//   resp_err                    misaligned/illegal flag
//   MemWrite, MemRead,          data memory strobes
//   Address, WriteData          word index and full write word
//   ReadData                    async memory read data
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       wr_word_q;
  logic [31:0]       rdata_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic        unused_upper;

  assign accept = req_valid && req_ready;

  // Upper address bits only matter when the bounds check is built in.
  assign unused_upper = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (|req_addr[31:ADDR_W+2]) req_err = 1'b1;
`endif
  end

  // Load extraction and sub-word merge, both keyed on the latched address.
  assign byte_sh   = {addr_q[1:0], 3'b000};
  assign half_sh   = {addr_q[1], 4'b0000};
  assign byte_word = ReadData >> byte_sh;
  assign half_word = ReadData >> half_sh;

  always_comb begin
    load_ext = ReadData;
    case (size_q)
      2'b00: load_ext = {{24{signed_q & byte_word[7]}}, byte_word[7:0]};
      2'b01: load_ext = {{16{signed_q & half_word[15]}}, half_word[15:0]};
      default: load_ext = ReadData;
    endcase
  end

  always_comb begin
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00ff << byte_sh;
      lane_data = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = 32'h0000_ffff << half_sh;
      lane_data = {2{wdata_q[15:0]}};
    end
    merged = (ReadData & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q    <= req_addr[ADDR_W+1:0];
        wdata_q   <= req_wdata[15:0];
        wr_word_q <= req_wdata;
        rdata_q   <= '0;
        size_q    <= req_size;
        signed_q  <= req_signed;
        err_q     <= req_err;
      end
      if (state == S_LOAD)   rdata_q   <= load_ext;
      if (state == S_RMW_RD) wr_word_q <= merged;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                state_next = S_RESP;
          else if (!req_write)        state_next = S_LOAD;
          else if (req_size == 2'b10) state_next = S_WRITE;
          else                        state_next = S_RMW_RD;
        end
      end
      S_LOAD:   state_next = S_RESP;
      S_RMW_RD: state_next = S_WRITE;
      S_WRITE:  state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Strobes are gated by Reset so nothing commits on a reset edge.
  assign req_ready  = (state == S_IDLE) && !Reset;
  assign MemRead    = ((state == S_LOAD) || (state == S_RMW_RD)) && !Reset;
  assign MemWrite   = (state == S_WRITE) && !Reset;
  assign Address    = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign WriteData  = (state == S_WRITE) ? wr_word_q : '0;
  assign resp_valid = (state == S_RESP);
  assign resp_err   = (state == S_RESP) && err_q;
  assign resp_rdata = (state == S_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-addressed memory model attached to the
// port, transaction-level reference memory, one per-cycle compare process.
module tb_load_store_unit;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data memory attached to the port ----------------
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] seed_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign ReadData = mem[Address[ADDR_W-1:0]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_val(i);
      mem_init <= 1'b1;
    end else if (MemWrite) begin
      mem[Address[ADDR_W-1:0]] <= WriteData;
    end
  end

  // ---------------- counters / check helper ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if ((addr >> (ADDR_W + 2)) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr);
    logic [31:0] v;
    int          bits;
    if (size == 2'd2) return word;
    bits = (size == 2'd0) ? 8 : 16;
    v = word >> (8 * (addr % 4));
    v = v & ((32'd1 << bits) - 32'd1);
    if (sgn && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    int          n;
    int          lane0;
    if (size == 2'd2) return data;
    n     = (size == 2'd0) ? 1 : 2;
    lane0 = int'(addr % 4);
    r     = old;
    for (int i = 0; i < n; i++) r[8*(lane0+i) +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q [$];
  logic        pend = 1'b0;
  int          acc_cyc = 0;
  int          exp_at = 0;
  logic        exp_err = 1'b0;
  int          exp_rd_n = 0;
  int          exp_wr_n = 0;
  logic [31:0] exp_word = '0;
  logic [31:0] exp_wdata = '0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic        resp_now;
    logic [31:0] exp_r;
    if (Reset) begin
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
    end else begin
      resp_now = pend && ((cyc - acc_cyc) == exp_at);
      chk("req_ready", 32'(req_ready), 32'(!pend));
      chk("rd_wr_exclusive", 32'(MemRead && MemWrite), 32'd0);
      if (MemRead || MemWrite) begin
        chk("access_allowed", 32'(pend && !exp_err && !resp_now), 32'd1);
        chk("access_addr", Address, exp_word);
        if (MemRead) rd_seen++;
        if (MemWrite) begin
          wr_seen++;
          chk("write_data", WriteData, exp_wdata);
        end
      end
      chk("resp_valid", 32'(resp_valid), 32'(resp_now));
      if (resp_now) begin
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("resp_rdata", resp_rdata, exp_r);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("mem_read_cycles", 32'(rd_seen), 32'(exp_rd_n));
        chk("mem_write_cycles", 32'(wr_seen), 32'(exp_wr_n));
        last_rdata = resp_rdata;
        last_err   = resp_err;
        last_lat   = cyc - acc_cyc + 1;
        pend       = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output logic ok);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    ok = req_ready;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd);
    logic ok;
    logic e;
    int   w;
    int   g;
    wait_ready(ok);
    if (!ok) return;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    e = model_err(sz, ad);
    w = int'((ad >> 2) % DEPTH);
    exp_err   = e;
    exp_word  = 32'(w);
    exp_at    = e ? 0 : ((wr && sz != 2'd2) ? 2 : 1);
    exp_rd_n  = (!e && (!wr || sz != 2'd2)) ? 1 : 0;
    exp_wr_n  = (!e && wr) ? 1 : 0;
    exp_wdata = model_store(ref_mem[w], sz, ad, wd);
    exp_q.push_back((e || wr) ? 32'd0 : model_load(ref_mem[w], sz, sg, ad));
    if (!e && wr) ref_mem[w] = exp_wdata;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    rd_seen = 0;
    wr_seen = 0;
    pend    = 1'b1;
    // While busy, wiggle the request inputs; they must be ignored.
    g = 0;
    while (pend && g < 20) begin
      @(negedge clk);
      #1;
      if (pend) begin
        req_valid  = 1'($urandom_range(0, 1));
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      g++;
    end
    req_valid = 1'b0;
    if (pend) begin
      chk("resp_timeout", 32'd0, 32'd1);
      pend = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic reset_during_write(input logic [31:0] ad, input logic [31:0] wd);
    logic ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_signed = 1'b0;
    req_addr  = ad;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    Reset     = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("reset_write_dropped", mem[(ad >> 2) % DEPTH], ref_mem[(ad >> 2) % DEPTH]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    int          r;
    int          mism;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
    Reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_address", Address, 32'd0);
    chk("reset_writedata", WriteData, 32'd0);
    chk("reset_memread", 32'(MemRead), 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;

    // Word store then word load.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("sw_latency", 32'(last_lat), 32'd2);
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("lw_err", 32'(last_err), 32'd0);
    chk("lw_latency", 32'(last_lat), 32'd2);

    // Byte store via read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAA);
    chk("sb_latency", 32'(last_lat), 32'd3);
    chk("sb_mem", mem[4], 32'h11AA_3344);

    // Extension cases.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("lb_signed", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    chk("lbu", last_rdata, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    chk("lh_signed_hi", last_rdata, 32'hFFFF_80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    chk("lh_signed_lo", last_rdata, 32'h0000_7F01);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
    chk("sh_mem", mem[4], 32'hBEEF_7F01);

    // Error requests.
    do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'h0);
    chk("err_half_flag", 32'(last_err), 32'd1);
    chk("err_half_latency", 32'(last_lat), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF);
    chk("err_word_flag", 32'(last_err), 32'd1);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h1234_5678);
    chk("err_size_flag", 32'(last_err), 32'd1);
    chk("err_size_rdata", last_rdata, 32'd0);
    chk("err_mem_unchanged", mem[4], 32'hBEEF_7F01);

    // Reset while the write is in flight.
    reset_during_write(32'h20, 32'h55);

    // Upper address bits.
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("bounds_err", 32'(last_err), 32'd1);
`else
    chk("bounds_wrap_rdata", last_rdata, ref_mem[0]);
    chk("bounds_wrap_err", 32'(last_err), 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      sg = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 255));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) ad[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) ad[31:12] = 20'($urandom_range(1, 15));
      do_req(wr, sz, sg, ad, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_mem_mismatches", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
